// File: rtl/alu_mul_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : alu_mul_sequencer
// Brief    : Shift-add unsigned multiplier that sequences an external
//            combinational ALU (AND for masking, ADD for accumulation).
//            Optional macro ZERO_SKIP_EN skips the ADD step when the
//            masked partial product is zero.
// Revision : 1.0 - initial release
// ============================================================================
module alu_mul_sequencer #(
  parameter int N = 12
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] product,
  output logic [N-1:0]   alu_in0,
  output logic [N-1:0]   alu_in1,
  output logic [1:0]     alu_op,
  input  logic [N-1:0]   alu_out,
  input  logic           alu_cy,
  input  logic           alu_zero
);

  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] C_LAST   = CW'(N - 1);
  localparam logic [1:0]    C_OP_AND = 2'b00;
  localparam logic [1:0]    C_OP_ADD = 2'b01;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_MASK  = 3'd1,
    S_ADD   = 3'd2,
    S_SHIFT = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [N-1:0]     m_q, m_d;
  logic [N-1:0]     q_q, q_d;
  logic [N-1:0]     acc_q, acc_d;
  logic [N-1:0]     p_q, p_d;
  logic             c_q, c_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [2*N-1:0]   product_q, product_d;

`ifndef ZERO_SKIP_EN
  logic w_unused_zero;
  assign w_unused_zero = alu_zero;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      m_q       <= '0;
      q_q       <= '0;
      acc_q     <= '0;
      p_q       <= '0;
      c_q       <= 1'b0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      m_q       <= m_d;
      q_q       <= q_d;
      acc_q     <= acc_d;
      p_q       <= p_d;
      c_q       <= c_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    m_d       = m_q;
    q_d       = q_q;
    acc_d     = acc_q;
    p_d       = p_q;
    c_d       = c_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    busy      = 1'b1;
    done      = 1'b0;
    alu_op    = C_OP_AND;
    alu_in0   = '0;
    alu_in1   = '0;

    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          m_d     = a;
          q_d     = b;
          acc_d   = '0;
          c_d     = 1'b0;
          cnt_d   = '0;
          state_d = S_MASK;
        end
      end
      S_MASK: begin
        // AND with a replicated multiplier bit selects M or zero
        alu_in0 = m_q;
        alu_in1 = {N{q_q[0]}};
        p_d     = alu_out;
        state_d = S_ADD;
`ifdef ZERO_SKIP_EN
        if (alu_zero) begin
          p_d     = '0;
          state_d = S_SHIFT;
        end
`endif
      end
      S_ADD: begin
        alu_op         = C_OP_ADD;
        alu_in0        = acc_q;
        alu_in1        = p_q;
        {c_d, acc_d}   = {alu_cy, alu_out};
        state_d        = S_SHIFT;
      end
      S_SHIFT: begin
        // carry re-enters the top of the accumulator, so no bits are lost
        {acc_d, q_d} = {c_q, acc_q, q_q[N-1:1]};
        c_d          = 1'b0;
        cnt_d        = cnt_q + CW'(1);
        if (cnt_q == C_LAST) begin
          product_d = {c_q, acc_q, q_q[N-1:1]};
          state_d   = S_DONE;
        end else begin
          state_d   = S_MASK;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign product = product_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_mul_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_mul_sequencer
// Brief    : Scoreboard bench for alu_mul_sequencer with a behavioural ALU.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_mul_sequencer;

  localparam int N = 12;

  logic           clk;
  logic           rst;
  logic           start;
  logic [N-1:0]   a;
  logic [N-1:0]   b;
  logic           busy;
  logic           done;
  logic [2*N-1:0] product;
  logic [N-1:0]   alu_in0;
  logic [N-1:0]   alu_in1;
  logic [1:0]     alu_op;
  logic [N-1:0]   alu_out;
  logic           alu_cy;
  logic           alu_zero;

  int checks = 0;
  int errors = 0;

  logic [2*N-1:0] sb_q[$];

  alu_mul_sequencer #(.N(N)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .product  (product),
    .alu_in0  (alu_in0),
    .alu_in1  (alu_in1),
    .alu_op   (alu_op),
    .alu_out  (alu_out),
    .alu_cy   (alu_cy),
    .alu_zero (alu_zero)
  );

  // Combinational ALU: 00 = AND, 01 = ADD with carry out
  always_comb begin
    if (alu_op == 2'b01) {alu_cy, alu_out} = {1'b0, alu_in0} + {1'b0, alu_in1};
    else                 {alu_cy, alu_out} = {1'b0, alu_in0 & alu_in1};
    alu_zero = (alu_out == '0);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic int exp_lat(input logic [N-1:0] ma, input logic [N-1:0] mb);
    int l;
    l = 1;
    for (int i = 0; i < N; i++) begin
`ifdef ZERO_SKIP_EN
      l += (mb[i] && ma != '0) ? 3 : 2;
`else
      l += 3;
`endif
    end
    return l;
  endfunction

  // Scoreboard: every done pops one expected product
  always @(negedge clk) begin
    if (done) begin
      check("done_busy", {63'd0, busy}, 64'd1);
      if (sb_q.size() == 0) begin
        check("spurious_done", 64'd1, 64'd0);
      end else begin
        check("product", {40'd0, product}, {40'd0, sb_q.pop_front()});
      end
    end
  end

  task automatic run_op(input logic [N-1:0] ma, input logic [N-1:0] mb, input bit hammer);
    int lat;
    logic [2*N-1:0] exp_p;
    exp_p = {{N{1'b0}}, ma} * {{N{1'b0}}, mb};
    a     = ma;
    b     = mb;
    start = 1'b1;
    sb_q.push_back(exp_p);
    lat = 0;
    while (1) begin
      @(negedge clk);
      lat++;
      if (hammer) begin
        a     = N'($urandom);
        b     = N'($urandom);
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (done) break;
      if (lat > 200) begin
        check("done_timeout", 64'd0, 64'd1);
        break;
      end
    end
    check("latency", lat, exp_lat(ma, mb));
    start = 1'b0;
    @(negedge clk);
    check("busy_after", {63'd0, busy}, 64'd0);
    check("done_after", {63'd0, done}, 64'd0);
    check("product_hold", {40'd0, product}, {40'd0, exp_p});
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_busy"},    {63'd0, busy},    64'd0);
    check({tag, "_done"},    {63'd0, done},    64'd0);
    check({tag, "_product"}, {40'd0, product}, 64'd0);
    check({tag, "_aluio"},   {38'd0, alu_in0, alu_in1, alu_op}, 64'd0);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    repeat (3) @(negedge clk);
    check_zero_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    run_op(12'd3, 12'd5, 1'b0);
    run_op(12'd4095, 12'd4095, 1'b0);
    run_op(12'd0, 12'd1234, 1'b0);
    run_op(12'd100, 12'd1, 1'b0);
    run_op(12'd7, 12'd9, 1'b1);
    for (int k = 0; k < 4; k++) run_op(N'($urandom), N'($urandom), 1'b0);

    // Abort mid-operation with an asynchronous reset
    a     = 12'd55;
    b     = 12'd77;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    check("abort_busy_before", {63'd0, busy}, 64'd1);
    #2 rst = 1'b1;
    sb_q.delete();
    #1;
    check_zero_outputs("abort");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done) check("abort_no_done", 64'd1, 64'd0);
    end
    check("abort_idle", {63'd0, busy}, 64'd0);
    run_op(12'd2, 12'd3, 1'b0);

    repeat (2) @(negedge clk);
    check("sb_empty", sb_q.size(), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_mul_sequencer.md
Name: alu_mul_sequencer

Overview:
Multi-cycle unsigned shift-add multiplier that acts as the initiator for the team's combinational N-bit ALU. It drives the ALU operand and opcode inputs, and consumes the ALU result, carry and zero flag. It sits beside the ALU in the datapath and exposes a start/busy/done handshake to the controller. Product is 2N bits.

Parameters:
- n, 12, operand width in bits; must match the attached ALU's n.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- start  in  1  request; sampled only in IDLE
- a  in  n  multiplicand; captured on accepted start
- b  in  n  multiplier; captured on accepted start
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse; product is valid in that cycle
- product  out  2n  result; held until the next DONE
- alu_in0  out  n  to ALU in0
- alu_in1  out  n  to ALU in1
- alu_op  out  2  to ALU ALUop (00 = AND, 01 = ADD)
- alu_out  in  n  from ALU out
- alu_cy  in  1  from ALU CY
- alu_zero  in  1  from ALU zero

Behaviour:
- Reset (async, rst=1): state=IDLE; all registers and outputs are 0, including product, done, busy, alu_in0, alu_in1 and alu_op. Reset during an operation aborts it and produces no done.
- Internal registers:
  - M (n): multiplicand
  - Q (n): multiplier, which becomes the product low half
  - A (n): accumulator high half
  - C (1): carry
  - P (n): partial product
  - cnt: iteration count, ceil(log2(n+1)) bits
- The ALU is combinational, so its result is sampled at the clock edge that ends the cycle in which the operands are driven.
- IDLE: alu_op=00, alu_in0=alu_in1=0. On start=1: M<=a, Q<=b, A<=0, C<=0, cnt<=0, go to MASK.
- MASK: alu_op=00, alu_in0=M, alu_in1={n{Q[0]}}. At the edge: P<=alu_out, go to ADD.
- ADD: alu_op=01, alu_in0=A, alu_in1=P. At the edge: {C,A}<={alu_cy,alu_out}, go to SHIFT.
- SHIFT: alu_op=00, alu_in0=alu_in1=0. At the edge: {C,A,Q}<={1'b0,C,A,Q}>>0 shifted right by one (C enters A[n-1], A[0] enters Q[n-1], C<=0), cnt<=cnt+1.
  - If cnt==n-1: go to DONE.
  - Otherwise: go to MASK.
- DONE: product<={A,Q}, done=1 for this cycle only, busy=1. Go to IDLE. start is ignored in DONE.
- start while busy=1 is ignored; no queuing.
- Latency: done is high exactly 3n+1 cycles after the edge that accepted start (37 for n=12). The next start can be accepted in the cycle after done.
- alu_cy is only sampled in ADD. alu_zero is unused unless ZERO_SKIP_EN is defined.
- Arithmetic is unsigned. The carry out of each add is preserved via C, so no overflow is possible in the 2n-bit product.

Optional Feature:
- Macro: ZERO_SKIP_EN
- Defined: in MASK, if alu_zero=1 (partial product is 0), skip ADD: go directly to SHIFT with P<=0 and C unchanged (C=0). Each iteration with a zero partial costs 2 cycles instead of 3. Latency = 1 + sum over iterations of (2 or 3) cycles.
- Undefined: fixed latency 3n+1 cycles; alu_zero is ignored.
- Product is identical in both builds.

Test Plan:
- n=12, a=3, b=5, start pulse -> done high 37 cycles later, product=15, busy high through DONE, then busy=0.
- a=4095, b=4095 -> product=16769025 (0xFFE001); exercises alu_cy=1 propagation through C.
- a=0, b=1234 -> product=0. With ZERO_SKIP_EN, done after 25 cycles.
- b=1, a=100 with ZERO_SKIP_EN -> product=100, done after 26 cycles. Without it -> 37 cycles.
- start re-asserted every cycle during an operation with a=7, b=9 -> only the first operation runs, product=63; new inputs are ignored until IDLE.
- rst asserted mid-operation (cycle 10), then a=2, b=3 started -> all outputs 0 immediately on rst, no done for the aborted operation, then product=6 after a clean 37-cycle run.
